// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared types and constants for the bit-serial subtractor.
//            Holds the FSM state encoding and the default operand width.
// Revision : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

    // Default operand/result width in bits.
    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ssub_state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Purpose  : One-bit combinational full subtractor cell, d = x - y - bin.
// Ports    : x    in  1  minuend bit
//            y    in  1  subtrahend bit
//            bin  in  1  borrow in
//            d    out 1  difference bit
//            bout out 1  borrow out
// Revision : 1.0  initial release
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow ripples in.
    assign bout = (~x & y) | (~w_xy & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one
//            bit per clock, built around a single full_subtractor cell and a
//            borrow flip-flop. start/done handshake.
// Ports    : clk        in   1      rising-edge clock
//            rst        in   1      synchronous active-high reset
//            start      in   1      request, sampled only in IDLE
//            a, b       in   WIDTH  operands, captured on the accepting edge
//            busy       out  1      high while not IDLE
//            done       out  1      one-cycle result-valid pulse
//            diff       out  WIDTH  a - b modulo 2^WIDTH
//            borrow_out out  1      1 iff a < b (unsigned)
//            ovf        out  1      signed overflow flag
// Config   : SERIAL_SUB_OVF_EN - when defined, ovf reports two's-complement
//            overflow; otherwise ovf is tied to 0 and no MSB latches exist.
// Revision : 1.0  initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int            c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    ssub_state_t      r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic [c_CW-1:0]  r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             w_d;
    logic             w_bout;

    full_subtractor u_cell (
        .x    (r_a_sh[0]),
        .y    (r_b_sh[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_d_sh       <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // Difference bits enter at the MSB so that after WIDTH
                    // shifts the LSB-first result sits in natural order.
                    r_d_sh   <= {w_d, r_d_sh[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_borrow <= w_bout;
                    if (r_cnt == c_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                DONE: begin
                    r_diff       <= r_d_sh;
                    r_borrow_out <= r_borrow;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits are kept because the shift registers lose them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == DONE) begin
            r_ovf <= (r_a_msb != r_b_msb) && (r_d_sh[WIDTH-1] != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule : serial_subtractor
`default_nettype wire
